// File: rtl/irq_pkg.sv
// irq_pkg
//   Shared constants, enums and helpers for the interrupt acknowledge
//   controller that sits between the peripherals, the 27-channel priority
//   encoder (three groups of nine) and the CPU.
//   Contents:
//     NCH, CHW   channels per group and channel-code width
//     grp_t      group code presented to the CPU (00 = none)
//     state_t    controller FSM states
//     pend_hit   checks that an encoder code names a pending bit
package irq_pkg;

    localparam int NCH = 9;
    localparam int CHW = 4;

    typedef enum logic [1:0] {
        GRP_NONE = 2'b00,
        GRP_A    = 2'b01,
        GRP_B    = 2'b10,
        GRP_C    = 2'b11
    } grp_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        PRESENT,
        CLEAR
    } state_t;

    // The encoder's code is only trusted when it points inside the group and
    // at a bit that really is pending here; a shift past bit 8 yields zero.
    function automatic logic pend_hit(input logic [NCH-1:0] pend,
                                      input logic [CHW-1:0] idx);
        logic [NCH-1:0] mask;
        mask = NCH'(1) << idx;
        return (idx <= CHW'(NCH-1)) && (|(pend & mask));
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// irq_edge_latch
//   Rising-edge detector plus sticky pending register for one group of
//   request lines. One instance per encoder group.
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   synchronous active-high reset
//     req      in   NCH request lines from the peripherals
//     clr      in   clear strobe for the granted bit
//     clr_idx  in   index of the bit to clear
//     pend     out  NCH sticky pending bits, feeds the encoder
module irq_edge_latch
    import irq_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req,
    input  logic           clr,
    input  logic [CHW-1:0] clr_idx,
    output logic [NCH-1:0] pend
);

    logic [NCH-1:0] req_prev;
    logic [NCH-1:0] set_mask;
    logic [NCH-1:0] clr_mask;

    assign set_mask = req & ~req_prev;
    assign clr_mask = clr ? (NCH'(1) << clr_idx) : '0;

    // Set is OR-ed in after the clear so a fresh edge arriving in the same
    // cycle as the acknowledge is never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev <= '0;
            pend     <= '0;
        end else begin
            req_prev <= req;
            pend     <= (pend & ~clr_mask) | set_mask;
        end
    end

endmodule

// File: rtl/irq_ack_ctrl.sv
// irq_ack_ctrl
//   CPU-side responder for the 27-channel priority interrupt encoder.
//   Latches requests into pending registers that drive the encoder, waits
//   for the encoder to settle, samples its status and presents one vector
//   at a time to the CPU with a valid/ack handshake.
//   Ports:
//     clk, rst               clock and synchronous active-high reset
//     req_a/b/c              request lines per group
//     pa, pb, pc, chan       encoder status and channel code
//     pend_a/b/c             pending bits to the encoder
//     irq_valid/grp/chan     vector presented to the CPU
//     cpu_ack                CPU accepts the vector
//     ack_done               pulse: granted pending bit cleared
//     irq_err                pulse: illegal encoder code or ack timeout
module irq_ack_ctrl
    import irq_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic           pa,
    input  logic           pb,
    input  logic           pc,
    input  logic [CHW-1:0] chan,
    output logic [NCH-1:0] pend_a,
    output logic [NCH-1:0] pend_b,
    output logic [NCH-1:0] pend_c,
    output logic           irq_valid,
    output logic [1:0]     irq_grp,
    output logic [CHW-1:0] irq_chan,
    input  logic           cpu_ack,
    output logic           ack_done,
    output logic           irq_err
);

    localparam int CNT_W = 4;
    localparam int TMR_W = 16;

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [TMR_W-1:0]   timer, timer_n;
    grp_t               grp_q, grp_n;
    logic [CHW-1:0]     chan_q, chan_n;
    grp_t               sel;
    logic [NCH-1:0]     sel_pend;
    logic               clr_a, clr_b, clr_c;

    // Only the granted bit of the granted group is cleared, during CLEAR.
    assign clr_a = (state == CLEAR) && (grp_q == GRP_A);
    assign clr_b = (state == CLEAR) && (grp_q == GRP_B);
    assign clr_c = (state == CLEAR) && (grp_q == GRP_C);

    irq_edge_latch u_lat_a (
        .clk(clk), .rst(rst), .req(req_a), .clr(clr_a), .clr_idx(chan_q), .pend(pend_a)
    );
    irq_edge_latch u_lat_b (
        .clk(clk), .rst(rst), .req(req_b), .clr(clr_b), .clr_idx(chan_q), .pend(pend_b)
    );
    irq_edge_latch u_lat_c (
        .clk(clk), .rst(rst), .req(req_c), .clr(clr_c), .clr_idx(chan_q), .pend(pend_c)
    );

    assign irq_valid = (state == PRESENT);
    assign irq_grp   = (state == PRESENT) ? grp_q : GRP_NONE;
    assign irq_chan  = (state == PRESENT) ? chan_q : '0;
    assign ack_done  = (state == CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            timer  <= '0;
            grp_q  <= GRP_NONE;
            chan_q <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            timer  <= timer_n;
            grp_q  <= grp_n;
            chan_q <= chan_n;
        end
    end

    // irq_err is decided combinationally so the pulse lands in the cycle
    // where the fault is detected (last WAIT cycle or last PRESENT cycle).
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        timer_n  = timer;
        grp_n    = grp_q;
        chan_n   = chan_q;
        irq_err  = 1'b0;
        sel      = GRP_NONE;
        sel_pend = '0;
        case (state)
            IDLE: begin
                if (|{pend_a, pend_b, pend_c}) begin
                    state_n = WAIT;
                    cnt_n   = CNT_W'(SETTLE - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    if (pa) begin
                        sel      = GRP_A;
                        sel_pend = pend_a;
                    end else if (pb) begin
                        sel      = GRP_B;
                        sel_pend = pend_b;
                    end else if (pc) begin
                        sel      = GRP_C;
                        sel_pend = pend_c;
                    end
                    if (sel == GRP_NONE) begin
                        state_n = IDLE;
                    end else if (pend_hit(sel_pend, chan)) begin
                        state_n = PRESENT;
                        grp_n   = sel;
                        chan_n  = chan;
                        timer_n = '0;
                    end else begin
                        irq_err = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            PRESENT: begin
                if (cpu_ack) begin
                    state_n = CLEAR;
                end else if (timer >= TMR_W'(TIMEOUT - 1)) begin
                    irq_err = 1'b1;
                    state_n = IDLE;
                end else if (timer != '1) begin
                    timer_n = timer + TMR_W'(1);
                end
            end
            CLEAR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_ack_ctrl.sv
// tb_irq_ack_ctrl
//   Self-checking bench for irq_ack_ctrl. A small behavioural model of the
//   priority encoder (lowest pending index wins inside a group, A > B > C)
//   feeds pa/pb/pc/chan back from the pending outputs, with an override for
//   injecting illegal codes.
module tb_irq_ack_ctrl;
    import irq_pkg::*;

    localparam int SETTLE  = 2;
    localparam int TIMEOUT = 4;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] req_a, req_b, req_c;
    logic           pa, pb, pc;
    logic [CHW-1:0] chan;
    logic [NCH-1:0] pend_a, pend_b, pend_c;
    logic           irq_valid;
    logic [1:0]     irq_grp;
    logic [CHW-1:0] irq_chan;
    logic           cpu_ack;
    logic           ack_done;
    logic           irq_err;

    logic           ov_en;
    logic           ov_pa;
    logic [CHW-1:0] ov_chan;

    int compared;
    int mismatched;

    typedef struct {
        logic [1:0]     grp;
        logic [CHW-1:0] idx;
        logic [1:0]     exp_grp;
        logic [CHW-1:0] exp_chan;
    } vec_t;

    vec_t vecs[6];

    irq_ack_ctrl #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .pa(pa), .pb(pb), .pc(pc), .chan(chan),
        .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c),
        .irq_valid(irq_valid), .irq_grp(irq_grp), .irq_chan(irq_chan),
        .cpu_ack(cpu_ack), .ack_done(ack_done), .irq_err(irq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CHW-1:0] lowBit(input logic [NCH-1:0] v);
        logic [CHW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (v[i]) r = CHW'(i);
        end
        return r;
    endfunction

    // Encoder model: group status is the OR of its pending bits.
    always_comb begin
        pa   = |pend_a;
        pb   = |pend_b;
        pc   = |pend_c;
        chan = pa ? lowBit(pend_a) : pb ? lowBit(pend_b) : lowBit(pend_c);
        if (ov_en) begin
            pa   = ov_pa;
            pb   = 1'b0;
            pc   = 1'b0;
            chan = ov_chan;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One-cycle rising-edge pulse on a single request line.
    task automatic applyStimulus(input logic [1:0] grp, input logic [CHW-1:0] idx);
        case (grp)
            2'b01:   req_a = NCH'(1) << idx;
            2'b10:   req_b = NCH'(1) << idx;
            default: req_c = NCH'(1) << idx;
        endcase
        tick();
        req_a = '0;
        req_b = '0;
        req_c = '0;
    endtask

    task automatic waitValid(input string name, input int budget);
        for (int i = 0; i < budget && !irq_valid; i++) tick();
        checkOutput(name, 32'(irq_valid), 32'd1);
    endtask

    task automatic ackVector(input string name);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        checkOutput({name, "_ack_done"}, 32'(ack_done), 32'd1);
        tick();
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        req_a      = '0;
        req_b      = '0;
        req_c      = '0;
        cpu_ack    = 1'b0;
        ov_en      = 1'b0;
        ov_pa      = 1'b0;
        ov_chan    = '0;

        vecs[0] = '{grp: 2'b01, idx: 4'd3, exp_grp: 2'b01, exp_chan: 4'd3};
        vecs[1] = '{grp: 2'b01, idx: 4'd0, exp_grp: 2'b01, exp_chan: 4'd0};
        vecs[2] = '{grp: 2'b01, idx: 4'd8, exp_grp: 2'b01, exp_chan: 4'd8};
        vecs[3] = '{grp: 2'b10, idx: 4'd5, exp_grp: 2'b10, exp_chan: 4'd5};
        vecs[4] = '{grp: 2'b11, idx: 4'd0, exp_grp: 2'b11, exp_chan: 4'd0};
        vecs[5] = '{grp: 2'b11, idx: 4'd8, exp_grp: 2'b11, exp_chan: 4'd8};

        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_valid", 32'(irq_valid), 32'd0);
        checkOutput("rst_grp", 32'(irq_grp), 32'd0);
        checkOutput("rst_ack_done", 32'(ack_done), 32'd0);
        checkOutput("rst_err", 32'(irq_err), 32'd0);
        checkOutput("rst_pend", 32'({pend_a, pend_b, pend_c}), 32'd0);

        // Single-request vectors: exact SETTLE+2 latency, handshake, clear.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].grp, vecs[v].idx);
            for (int k = 0; k < SETTLE; k++) tick();
            checkOutput($sformatf("vec%0d_early", v), 32'(irq_valid), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_valid", v), 32'(irq_valid), 32'd1);
            checkOutput($sformatf("vec%0d_grp", v), 32'(irq_grp), 32'(vecs[v].exp_grp));
            checkOutput($sformatf("vec%0d_chan", v), 32'(irq_chan), 32'(vecs[v].exp_chan));
            cpu_ack = 1'b1;
            tick();
            cpu_ack = 1'b0;
            checkOutput($sformatf("vec%0d_ack_done", v), 32'(ack_done), 32'd1);
            checkOutput($sformatf("vec%0d_valid_clr", v), 32'(irq_valid), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_ack_done_end", v), 32'(ack_done), 32'd0);
            checkOutput($sformatf("vec%0d_pend", v), 32'({pend_a, pend_b, pend_c}), 32'd0);
        end

        // Group priority: B/5 and C/0 together, B first then C.
        req_b = NCH'(1) << 5;
        req_c = NCH'(1);
        tick();
        req_b = '0;
        req_c = '0;
        for (int k = 0; k < SETTLE + 1; k++) tick();
        checkOutput("prio_valid1", 32'(irq_valid), 32'd1);
        checkOutput("prio_grp1", 32'(irq_grp), 32'd2);
        checkOutput("prio_chan1", 32'(irq_chan), 32'd5);
        ackVector("prio1");
        checkOutput("prio_pend_c", 32'(pend_c), 32'd1);
        waitValid("prio_valid2", 20);
        checkOutput("prio_grp2", 32'(irq_grp), 32'd3);
        checkOutput("prio_chan2", 32'(irq_chan), 32'd0);
        ackVector("prio2");
        checkOutput("prio_pend_end", 32'({pend_a, pend_b, pend_c}), 32'd0);

        // Set wins: fresh edge on A/3 lands on the CLEAR edge of A/3.
        applyStimulus(2'b01, 4'd3);
        waitValid("setwin_valid1", 20);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
        checkOutput("setwin_ack_done", 32'(ack_done), 32'd1);
        req_a = NCH'(1) << 3;
        tick();
        req_a = '0;
        checkOutput("setwin_pend", 32'(pend_a), 32'h008);
        waitValid("setwin_valid2", 20);
        checkOutput("setwin_grp2", 32'(irq_grp), 32'd1);
        checkOutput("setwin_chan2", 32'(irq_chan), 32'd3);
        ackVector("setwin2");
        checkOutput("setwin_pend_end", 32'(pend_a), 32'd0);

        // Timeout: no ack for TIMEOUT cycles of PRESENT.
        applyStimulus(2'b01, 4'd2);
        waitValid("tmo_valid", 20);
        for (int k = 1; k < TIMEOUT; k++) begin
            checkOutput($sformatf("tmo_err_c%0d", k), 32'(irq_err), 32'd0);
            tick();
        end
        checkOutput("tmo_err_pulse", 32'(irq_err), 32'd1);
        checkOutput("tmo_valid_last", 32'(irq_valid), 32'd1);
        tick();
        checkOutput("tmo_err_end", 32'(irq_err), 32'd0);
        checkOutput("tmo_valid_drop", 32'(irq_valid), 32'd0);
        checkOutput("tmo_pend_kept", 32'(pend_a), 32'h004);
        waitValid("tmo_re_valid", 20);
        checkOutput("tmo_re_chan", 32'(irq_chan), 32'd2);
        ackVector("tmo_re");

        // Illegal code: encoder claims A with chan 12.
        ov_en   = 1'b1;
        ov_pa   = 1'b1;
        ov_chan = 4'd12;
        applyStimulus(2'b01, 4'd1);
        for (int k = 0; k < SETTLE; k++) tick();
        checkOutput("ill_err", 32'(irq_err), 32'd1);
        checkOutput("ill_valid", 32'(irq_valid), 32'd0);
        tick();
        ov_en = 1'b0;
        checkOutput("ill_err_end", 32'(irq_err), 32'd0);
        checkOutput("ill_pend", 32'(pend_a), 32'h002);
        waitValid("ill_re_valid", 20);
        checkOutput("ill_re_chan", 32'(irq_chan), 32'd1);
        ackVector("ill_re");

        // Reset while a vector is presented.
        applyStimulus(2'b11, 4'd7);
        waitValid("rstp_valid", 20);
        rst = 1'b1;
        tick();
        checkOutput("rstp_valid0", 32'(irq_valid), 32'd0);
        checkOutput("rstp_grp0", 32'(irq_grp), 32'd0);
        checkOutput("rstp_chan0", 32'(irq_chan), 32'd0);
        checkOutput("rstp_ack_done", 32'(ack_done), 32'd0);
        checkOutput("rstp_err", 32'(irq_err), 32'd0);
        checkOutput("rstp_pend", 32'(pend_c), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        checkOutput("rstp_ack_done_after", 32'(ack_done), 32'd0);
        checkOutput("rstp_valid_after", 32'(irq_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
